// File: rtl/sprite_mover.sv
// Sprite mover: clears the VGA frame, draws a ROM-backed sprite, then steps it left/right
// with erase/clamp/redraw. Drives the x/y/colour/plot inputs of a VGA adapter.
module sprite_mover #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned SPRITE_W = 11,
  parameter int unsigned SPRITE_H = 10,
  parameter int unsigned X_START  = 73,
  parameter int unsigned Y_START  = 105,
  parameter int unsigned STEP     = 5,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                left_i,
  input  logic                right_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [COLOUR_W-1:0] rom_data_i,
  output logic [7:0]          xout_o,
  output logic [6:0]          yout_o,
  output logic [COLOUR_W-1:0] colour_out_o,
  output logic                plot_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                blocked_o,
  output logic [7:0]          sprite_x_o
);

  localparam int unsigned XMax = SCREEN_W - SPRITE_W;

  typedef enum logic [2:0] {
    StIdle, StClear, StDraw, StDone, StReady, StErase, StUpdate
  } state_e;

  state_e            state_q;
  logic [7:0]        cx_q;
  logic [6:0]        cy_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [7:0]        sprite_x_q;
  logic              dir_right_q;
  logic              left_q, right_q;
  logic [7:0]        xout_q;
  logic [6:0]        yout_q;
  logic              plot_q, draw_q, busy_q, done_q, blocked_q;

  logic [8:0] target;
  logic       at_edge;
  logic       spr_last_col, spr_last;
  logic       clr_last_col, clr_last;

  // 9-bit target so neither direction can wrap before clamping.
  always_comb begin
    target = 9'd0;
    if (dir_right_q) begin
      target = ({1'b0, sprite_x_q} + 9'(STEP) <= 9'(XMax)) ? {1'b0, sprite_x_q} + 9'(STEP)
                                                           : 9'(XMax);
    end else begin
      target = ({1'b0, sprite_x_q} >= 9'(STEP)) ? {1'b0, sprite_x_q} - 9'(STEP) : 9'd0;
    end
    at_edge      = (target == {1'b0, sprite_x_q});
    spr_last_col = (cx_q == 8'(SPRITE_W - 1));
    spr_last     = spr_last_col && (cy_q == 7'(SPRITE_H - 1));
    clr_last_col = (cx_q == 8'(SCREEN_W - 1));
    clr_last     = clr_last_col && (cy_q == 7'(SCREEN_H - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cx_q        <= '0;
      cy_q        <= '0;
      rom_addr_q  <= '0;
      sprite_x_q  <= 8'(X_START);
      dir_right_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      xout_q      <= '0;
      yout_q      <= '0;
      plot_q      <= 1'b0;
      draw_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      // Edge registers track the inputs in every state, so presses made while busy are lost.
      left_q    <= left_i;
      right_q   <= right_i;
      plot_q    <= 1'b0;
      draw_q    <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          xout_q <= cx_q;
          yout_q <= cy_q;
          plot_q <= 1'b1;
          if (clr_last) begin
            cx_q       <= '0;
            cy_q       <= '0;
            rom_addr_q <= '0;
            state_q    <= StDraw;
          end else if (clr_last_col) begin
            cx_q <= '0;
            cy_q <= cy_q + 7'd1;
          end else begin
            cx_q <= cx_q + 8'd1;
          end
        end
        StDraw, StErase: begin
          if (state_q == StErase && at_edge) begin
            blocked_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StReady;
          end else begin
            xout_q <= sprite_x_q + cx_q;
            yout_q <= 7'(Y_START) + cy_q;
            plot_q <= 1'b1;
            draw_q <= (state_q == StDraw);
            if (spr_last) begin
              cx_q    <= '0;
              cy_q    <= '0;
              state_q <= (state_q == StDraw) ? StDone : StUpdate;
            end else begin
              if (spr_last_col) begin
                cx_q <= '0;
                cy_q <= cy_q + 7'd1;
              end else begin
                cx_q <= cx_q + 8'd1;
              end
              if (state_q == StDraw) rom_addr_q <= rom_addr_q + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          rom_addr_q <= '0;
          state_q    <= StReady;
        end
        StReady: begin
          if (left_i && !left_q && !right_i) begin
            dir_right_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StErase;
          end else if (right_i && !right_q && !left_i) begin
            dir_right_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StErase;
          end
        end
        StUpdate: begin
          sprite_x_q <= target[7:0];
          rom_addr_q <= '0;
          state_q    <= StDraw;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign xout_o       = xout_q;
  assign yout_o       = yout_q;
  // Synchronous ROM answers one cycle after rom_addr, aligned with the registered x/y.
  assign colour_out_o = draw_q ? rom_data_i : '0;
  assign plot_o       = plot_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign blocked_o    = blocked_q;
  assign sprite_x_o   = sprite_x_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: clear/draw, clamped moves, blocked moves, edge detection,
// dropped requests while busy and asynchronous reset in the middle of a draw.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, left, right;
  logic [6:0] rom_addr;
  logic [2:0] rom_data;
  logic [7:0] xout;
  logic [6:0] yout;
  logic [2:0] colour_out;
  logic       plot, busy, done, blocked;
  logic [7:0] sprite_x;

  int checks   = 0;
  int failures = 0;

  int op_plots, op_bad, op_done, op_blocked, op_cycles, op_timeout;

  sprite_mover dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .left_i      (left),
    .right_i     (right),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .xout_o      (xout),
    .yout_o      (yout),
    .colour_out_o(colour_out),
    .plot_o      (plot),
    .busy_o      (busy),
    .done_o      (done),
    .blocked_o   (blocked),
    .sprite_x_o  (sprite_x)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input int a);
    int v;
    v = a ^ (a >> 3);
    return 3'(v);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: full-screen clear then sprite; mode 1: erase at sx_old then sprite at sx_new.
  function automatic void exp_pix(input int k, input int mode, input int sx_old,
                                  input int sx_new, output int ex, output int ey, output int ec);
    int j;
    int base;
    base = (mode == 0) ? 160 * 120 : 110;
    if (k < base) begin
      if (mode == 0) begin
        ex = k % 160; ey = k / 160;
      end else begin
        ex = sx_old + k % 11; ey = 105 + k / 11;
      end
      ec = 0;
    end else begin
      j  = k - base;
      ex = sx_new + j % 11;
      ey = 105 + j / 11;
      ec = int'(rom_fn(j));
    end
  endfunction

  task automatic run_op(input int budget, input int mode, input int sx_old, input int sx_new,
                        input int pl_at, input int pr_at, input int pr_extra);
    int ex, ey, ec;
    op_plots = 0; op_bad = 0; op_done = 0; op_blocked = 0; op_cycles = 0; op_timeout = 1;
    for (int i = 0; i < budget; i++) begin
      if (pl_at >= 0) left = (i == pl_at);
      if (pr_at >= 0 || pr_extra > 0)
        right = (i == pr_at) || (pr_extra > 0 && i >= pr_extra && (i - pr_extra) % 40 == 0);
      @(negedge clk);
      if (plot) begin
        exp_pix(op_plots, mode, sx_old, sx_new, ex, ey, ec);
        if (int'(xout) !== ex || int'(yout) !== ey || int'(colour_out) !== ec) op_bad++;
        op_plots++;
      end
      if (done) op_done++;
      if (blocked) op_blocked++;
      if (done || blocked) begin
        op_cycles  = i + 1;
        op_timeout = 0;
        break;
      end
    end
    if (pl_at >= 0) left = 1'b0;
    if (pr_at >= 0 || pr_extra > 0) right = 1'b0;
  endtask

  task automatic move(input bit dir_r, input int sx_old, input int sx_new);
    run_op(400, 1, sx_old, sx_new, dir_r ? -1 : 0, dir_r ? 0 : -1, 0);
    check("move_done", op_done, 1);
    check("move_plots", op_plots, 220);
    check("move_pixels_bad", op_bad, 0);
    check("move_latency", op_cycles, 223);
    check("move_sprite_x", int'(sprite_x), sx_new);
    check("move_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("move_done_width", int'(done), 0);
  endtask

  task automatic blocked_move(input bit dir_r, input int sx);
    run_op(50, 1, sx, sx, dir_r ? -1 : 0, dir_r ? 0 : -1, 0);
    check("blk_pulse", op_blocked, 1);
    check("blk_done", op_done, 0);
    check("blk_plots", op_plots, 0);
    check("blk_sprite_x", int'(sprite_x), sx);
    @(negedge clk);
    check("blk_width", int'(blocked), 0);
    check("blk_busy", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_blocked"}, int'(blocked), 0);
    check({tag, "_xout"}, int'(xout), 0);
    check({tag, "_yout"}, int'(yout), 0);
    check({tag, "_colour"}, int'(colour_out), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_sprite_x"}, int'(sprite_x), 73);
  endtask

  initial begin
    int sx;
    rst_n = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Initial clear and draw.
    start = 1'b1;
    run_op(25000, 0, 0, 73, -1, -1, 0);
    start = 1'b0;
    check("init_done", op_done, 1);
    check("init_plots", op_plots, 19200 + 110);
    check("init_pixels_bad", op_bad, 0);
    check("init_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("init_done_width", int'(done), 0);

    // Single left move, then walk to the left edge.
    move(1'b0, 73, 68);
    sx = 68;
    while (sx >= 5) begin
      move(1'b0, sx, sx - 5);
      sx = sx - 5;
    end
    check("walk_left_end", sx, 3);
    move(1'b0, 3, 0);
    blocked_move(1'b0, 0);

    // Walk to the right edge, last step clamped.
    sx = 0;
    while (sx + 5 <= 149) begin
      move(1'b1, sx, sx + 5);
      sx = sx + 5;
    end
    move(1'b1, 145, 149);
    blocked_move(1'b1, 149);

    // Both rising together: nothing happens.
    run_op(300, 1, 149, 149, 0, 0, 0);
    check("both_timeout", op_timeout, 1);
    check("both_plots", op_plots, 0);
    check("both_events", op_done + op_blocked, 0);

    // Left held high: exactly one move.
    left = 1'b1;
    run_op(600, 1, 149, 144, -1, -1, 0);
    check("held_done", op_done, 1);
    check("held_plots", op_plots, 220);
    check("held_pixels_bad", op_bad, 0);
    run_op(400, 1, 144, 144, -1, -1, 0);
    check("held_no_retrigger", op_plots + op_done + op_blocked, 0);
    left = 1'b0;

    // Right pulses while busy are dropped.
    run_op(400, 1, 144, 149, -1, 0, 20);
    check("busy_req_done", op_done, 1);
    check("busy_req_plots", op_plots, 220);
    check("busy_req_pixels_bad", op_bad, 0);
    check("busy_req_sprite_x", int'(sprite_x), 149);
    run_op(100, 1, 149, 149, -1, -1, 0);
    check("busy_req_not_queued", op_plots + op_done + op_blocked, 0);

    // Reset in the middle of the redraw.
    run_op(150, 1, 149, 144, 0, -1, 0);
    check("mid_timeout", op_timeout, 1);
    check("mid_plots", op_plots, 148);
    check("mid_pixels_bad", op_bad, 0);
    check("mid_busy", int'(busy), 1);
    check("mid_plot_high", int'(plot), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(300, 1, 73, 73, 0, -1, 0);
    check("idle_ignores_left", op_plots + op_done + op_blocked, 0);
    check("idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
